// File: rtl/i2s_speaker_tx.sv
// I2S serializer for the Pmod DAC: derives MCLK/SCK/LRCK from clk, captures one L/R pair per 512-clk frame.
// Latency: pair captured at the 511->0 edge; left MSB on sdin during cnt 8..15, right MSB during cnt 264..271.
// No backpressure: free-running; sample_req pulses in the cnt==511 cycle so upstream can update before capture.
module i2s_speaker_tx #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] audio_left,
  input  logic [DATA_W-1:0] audio_right,
  input  logic              mute,
  output logic              audio_mclk,
  output logic              audio_sck,
  output logic              audio_lrck,
  output logic              audio_sdin,
  output logic              sample_req
);

  logic [8:0]        cnt;
  logic [8:0]        cnt_nxt;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;

  logic [4:0]        slot_nxt;
  logic              half_nxt;
  logic [DATA_W-1:0] word_nxt;
  logic [DATA_W-1:0] word_shift;
  logic [5:0]        bit_idx;
  logic              bit_nxt;

  assign cnt_nxt  = cnt + 9'd1;
  assign slot_nxt = cnt_nxt[7:3];
  assign half_nxt = cnt_nxt[8];

  // Clock outputs are plain counter bits, so they come straight from flops.
  assign audio_mclk = cnt[1];
  assign audio_sck  = cnt[2];
  assign audio_lrck = cnt[8];

  // Pick the data bit for the slot the counter is about to enter; slot 0 is the I2S delay bit.
  always_comb begin
    word_nxt   = half_nxt ? hold_r : hold_l;
    bit_idx    = 6'(DATA_W) - {1'b0, slot_nxt};
    word_shift = word_nxt >> bit_idx;
    bit_nxt    = 1'b0;
    if ((slot_nxt != 5'd0) && ({1'b0, slot_nxt} <= 6'(DATA_W))) begin
      bit_nxt = word_shift[0];
    end
  end

  // Frame counter, sample capture at the frame wrap, and registered sdin/sample_req.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 9'd0;
      hold_l     <= '0;
      hold_r     <= '0;
      audio_sdin <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      // The wrap edge enters slot 0, whose output ignores the holds, so loading here is safe.
      if (cnt == 9'd511) begin
        hold_l <= mute ? '0 : audio_left;
        hold_r <= mute ? '0 : audio_right;
      end
      // bit_nxt only changes when cnt_nxt crosses a slot boundary, i.e. on SCK falling edges.
      audio_sdin <= bit_nxt;
      sample_req <= (cnt_nxt == 9'd511);
    end
  end

endmodule

// File: tb/tb_i2s_speaker_tx.sv
// Testbench for i2s_speaker_tx: cycle-level reference model of frame position and captured words,
// plus per-frame reassembly of the words seen at SCK rising edges.
module tb_i2s_speaker_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        mute;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;
  logic        sample_req;

  i2s_speaker_tx #(.DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .mute        (mute),
    .audio_mclk  (audio_mclk),
    .audio_sck   (audio_sck),
    .audio_lrck  (audio_lrck),
    .audio_sdin  (audio_sdin),
    .sample_req  (sample_req)
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame and the words being serialized this frame.
  int p;
  int ml;
  int mr;
  int n_chk  = 0;
  int n_fail = 0;
  int bits [2][32];
  int req_cnt;
  int lr_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sdin(input int pos);
    int h;
    int k;
    int w;
    h = pos / 256;
    k = (pos % 256) / 8;
    w = (h == 1) ? mr : ml;
    if (k >= 1 && k <= 16) return (w >> (16 - k)) & 1;
    return 0;
  endfunction

  task automatic check_all();
    chk("mclk", {31'd0, audio_mclk}, 32'((p / 2) % 2));
    chk("sck",  {31'd0, audio_sck},  32'((p / 4) % 2));
    chk("lrck", {31'd0, audio_lrck}, 32'((p >= 256) ? 1 : 0));
    chk("req",  {31'd0, sample_req}, 32'((p == 511) ? 1 : 0));
    chk("sdin", {31'd0, audio_sdin}, 32'(exp_sdin(p)));
  endtask

  // One clk: advance the model on the edge, then compare just after it.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      p = 0; ml = 0; mr = 0;
    end else begin
      if (p == 511) begin
        ml = mute ? 0 : int'(audio_left);
        mr = mute ? 0 : int'(audio_right);
      end
      p = (p + 1) % 512;
    end
    #1;
    check_all();
  endtask

  // Run one full frame from p==0, optionally changing inputs right after reaching position 'at'.
  task automatic run_frame(input int at, input logic [15:0] l, input logic [15:0] r, input logic m);
    for (int h = 0; h < 2; h++)
      for (int k = 0; k < 32; k++) bits[h][k] = 0;
    req_cnt = 0;
    lr_cnt  = 0;
    repeat (512) begin
      tick();
      if (p % 8 == 4) bits[p / 256][(p % 256) / 8] = (audio_sdin === 1'b1) ? 1 : 0;
      if (sample_req === 1'b1) req_cnt++;
      if (audio_lrck === 1'b1) lr_cnt++;
      if (p == at) begin
        audio_left = l; audio_right = r; mute = m;
      end
    end
    chk("req_per_frame", 32'(req_cnt), 32'd1);
    chk("lrck_high",     32'(lr_cnt),  32'd256);
  endtask

  function automatic logic [15:0] word_of(input int h);
    logic [15:0] w;
    w = '0;
    for (int k = 1; k <= 16; k++) w[16 - k] = bits[h][k][0];
    return w;
  endfunction

  task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
    int idle;
    idle = 0;
    for (int h = 0; h < 2; h++) begin
      idle += bits[h][0];
      for (int k = 17; k < 32; k++) idle += bits[h][k];
    end
    chk({tag, "_left"},  {16'd0, word_of(0)}, {16'd0, el});
    chk({tag, "_right"}, {16'd0, word_of(1)}, {16'd0, er});
    chk({tag, "_idle"},  32'(idle), 32'd0);
  endtask

  logic [15:0] cur_l;
  logic [15:0] cur_r;

  initial begin
    p = 0; ml = 0; mr = 0;
    rst = 1'b1;
    audio_left = 16'h1357; audio_right = 16'h2468; mute = 1'b0;
    #2 rst = 1'b0;
    #1 check_all();

    // Reset hold with inputs wiggling: everything stays 0.
    repeat (20) begin
      tick();
      audio_left  = 16'($urandom);
      audio_right = 16'($urandom);
    end

    // Release; frame 1 is silent, capture A5C3/3C0F at its end.
    rst = 1'b1;
    audio_left = 16'hA5C3; audio_right = 16'h3C0F; mute = 1'b0;
    run_frame(-1, 16'h0, 16'h0, 1'b0);
    check_frame("silent_first", 16'h0000, 16'h0000);

    // Serialization; left changes to FFFF mid-frame and must not disturb this frame.
    run_frame(100, 16'hFFFF, 16'h3C0F, 1'b0);
    check_frame("serial", 16'hA5C3, 16'h3C0F);

    // Capture isolation: FFFF shifts out while left drops to 0000 at cnt 100.
    run_frame(100, 16'h0000, 16'h3C0F, 1'b0);
    check_frame("isolate", 16'hFFFF, 16'h3C0F);

    // Mute asserted at cnt 50 leaves the current frame intact.
    run_frame(50, 16'h7FFF, 16'h7FFF, 1'b1);
    check_frame("mute_mid", 16'h0000, 16'h3C0F);

    // Muted capture gives a silent frame; inputs updated in the cnt==511 cycle.
    run_frame(511, 16'h1234, 16'h5678, 1'b0);
    check_frame("muted", 16'h0000, 16'h0000);

    run_frame(-1, 16'h0, 16'h0, 1'b0);
    check_frame("handshake", 16'h1234, 16'h5678);

    // Random traffic against the model.
    repeat (5) begin
      cur_l = 16'(ml);
      cur_r = 16'(mr);
      run_frame($urandom_range(511, 0), 16'($urandom), 16'($urandom), ($urandom_range(3, 0) == 0));
      check_frame("rand", cur_l, cur_r);
    end

    // Mid-frame reset at cnt 140: outputs clear without a clock edge.
    audio_left = 16'h7FFF; audio_right = 16'h4001; mute = 1'b0;
    repeat (140) tick();
    rst = 1'b0;
    #1;
    chk("rst_async_mclk", {31'd0, audio_mclk}, 32'd0);
    chk("rst_async_sck",  {31'd0, audio_sck},  32'd0);
    chk("rst_async_lrck", {31'd0, audio_lrck}, 32'd0);
    chk("rst_async_sdin", {31'd0, audio_sdin}, 32'd0);
    chk("rst_async_req",  {31'd0, sample_req}, 32'd0);
    p = 0; ml = 0; mr = 0;
    repeat (5) tick();
    rst = 1'b1;
    run_frame(-1, 16'h0, 16'h0, 1'b0);
    check_frame("post_reset", 16'h0000, 16'h0000);
    run_frame(-1, 16'h0, 16'h0, 1'b0);
    check_frame("post_reset2", 16'h7FFF, 16'h4001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_speaker_tx.md
# i2s_speaker_tx

Serializer stage directly downstream of the square-wave note generator. It takes the two 16-bit signed audio samples (left/right) and drives the Pmod I2S DAC. It generates MCLK, SCK and LRCK from the 100 MHz system clock, captures one sample pair per frame, and shifts it out MSB-first in I2S format. A per-frame request strobe and a mute input give the upstream stages a clean sample boundary.

## Interface
- DATA_W, 16, sample width in bits; legal range 1..31 (must fit in a 32-slot half-frame with 1 delay slot)
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- audio_left  in  DATA_W  left sample, two's complement, sampled only at frame capture edge
- audio_right  in  DATA_W  right sample, same rules
- mute  in  1  1 = load zeros instead of audio at capture edge
- audio_mclk  out  1  master clock, clk/4 (25 MHz)
- audio_sck  out  1  serial bit clock, clk/8 (12.5 MHz)
- audio_lrck  out  1  word select, clk/512 (195.3125 kHz); 0 = left, 1 = right
- audio_sdin  out  1  serial data to DAC
- sample_req  out  1  one-clk pulse marking the last cycle of a frame

## Operation
- Single free-running 9-bit counter cnt, +1 per clk, wraps 511 -> 0. One frame = 512 clk.
- Derived registered clocks:
  - audio_mclk = cnt[1]
  - audio_sck = cnt[2]
  - audio_lrck = cnt[8]
- Half-frame h = cnt[8]: 0 = left, 1 = right. Slot index k = cnt[7:3] (0..31). Each slot is 8 clk = one SCK period.
- Hold registers hold_l and hold_r (DATA_W each). They load on the clk edge where cnt goes 511 -> 0:
  - mute=0: load audio_left / audio_right.
  - mute=1: load 0.
  - They are stable for the whole following frame. Input changes at any other time are ignored.
- audio_sdin for slot k of half h:
  - k = 0: 0 (I2S one-bit delay after the LRCK transition).
  - 1 <= k <= DATA_W: bit (DATA_W - k) of hold_l (h=0) or hold_r (h=1), MSB first.
  - k > DATA_W: 0.
- sdin changes only on SCK falling edges, i.e. on the edge where cnt[2:0] wraps to 0. The DAC samples on SCK rising edges, mid-slot.
- sample_req = 1 exactly while cnt == 511. The upstream stage may change its inputs in response; the new values are captured on the next edge only if they are already stable at that edge.
- All outputs are driven from flops; none are combinational from inputs.

## Timing
- Reset (rst=0, asynchronous):
  - cnt = 0, hold_l = hold_r = 0.
  - All outputs = 0: mclk, sck, lrck, sdin, sample_req.
  - Takes effect immediately, including mid-frame or mid-bit. No partial word is completed.
- Release: the first edge with rst=1 advances cnt to 1. The first frame after reset serializes zeros, because the holds are still 0. The first captured sample goes out in frame 2.
- Capture-to-output latency: a sample captured at the 511 -> 0 edge appears as follows:
  - Left MSB on sdin during cnt 8..15.
  - Left LSB during cnt 8*DATA_W .. 8*DATA_W+7.
  - Right MSB during cnt 264..271.
- sample_req asserts at the edge into cnt=511 and deasserts at the edge into cnt=0, which is the same edge that captures.
- mute is sampled only at the capture edge. Toggling it mid-frame does not alter the frame in progress.
- Wrap: 511 -> 0 is seamless. lrck falls, slot 0 outputs 0, and there is no extra cycle.

## Test plan
- Reset hold: keep rst=0 for 20 clk while driving the audio inputs. All outputs stay 0. Release rst: mclk period 4 clk, sck period 8 clk, lrck period 512 clk with 256 high.
- Serialization: audio_left=16'hA5C3 and audio_right=16'h3C0F stable across the capture edge. Sampling sdin at each SCK rise in frame 2 gives left slots 1..16 = 1010_0101_1100_0011 and right slots 1..16 = 0011_1100_0000_1111; slots 0 and 17..31 are 0.
- Capture isolation: change audio_left from 16'hFFFF to 16'h0000 at cnt=100. The current frame still shifts 16'hFFFF, and the next frame shifts 16'h0000.
- Mute: mute=1 at the capture edge with audio=16'h7FFF. The next frame's sdin is all 0. Asserting mute at cnt=50 only does not affect the current frame.
- Handshake: sample_req is high for exactly 1 clk per 512, in the cycle cnt=511. An input updated in that cycle is captured and appears in the next frame.
- Mid-frame reset: assert rst at cnt=140, mid-left-word. Outputs go 0 within the same cycle, asynchronously. After release, lrck restarts low and frame 1 is silent.
